timer_irq_gen: RTL and testbench
================================

# timer_irq_gen

Memory-mapped interval timer that produces the level `Interrupt` request consumed by the CPU control unit, and is the source end of that signal. It sits on the data-memory bus beside data RAM, decodes its own register window from the CPU's `MemRd`/`MemWr` strobes, and masks its request while the CPU runs in kernel mode (PC[31]=1).

## Interface
Parameters:
- `BASE_ADDR`, default 32'h4000_0000: byte address of register window (4 words, word-aligned).

Ports:
- `clk`  input  1: system clock; all state on rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `addr`  input  32: CPU data address (ALU result).
- `wdata`  input  32: CPU store data.
- `MemRd`  input  1: load strobe from control unit.
- `MemWr`  input  1: store strobe from control unit.
- `kernel`  input  1: PC[31] of the instruction in flight; 1 = kernel mode.
- `rdata`  output  32: read data; 0 when not selected.
- `Interrupt`  output  1: level interrupt request to control unit.

## Operation
- Register map (offsets from `BASE_ADDR`): 0x0 TH (reload value), 0x4 TL (counter), 0x8 TCON, 0xC PRESC (see Configuration).
- TCON: bit0 EN (count enable), bit1 IE (interrupt enable), bit2 ST (sticky overflow status), bit3 OVR (overrun: overflow while ST already 1); bits 31:4 read 0, ignored on write.
- Select: `addr[31:4]==BASE_ADDR[31:4]`; `addr[1:0]` ignored. Non-selected accesses have no effect.
- Tick: one-cycle internal pulse; every cycle when PRESC is compiled out or PRESC==0.
- Count: on tick with EN=1: if TL==32'hFFFF_FFFF then TL<=TH, ST<=1 (OVR<=1 if ST was already 1); else TL<=TL+1. Wraps unsigned, no saturation.
- Period: 2^32 − TH ticks between overflows after reload.
- `Interrupt` = ST & IE & ~kernel (combinational on registered ST/IE and live `kernel`).
- Handshake: ISR clears request by writing TCON with bit2=0; request stays high (when unmasked) until cleared.
- Collisions, same edge:
  - CPU write to TL or TH vs overflow reload: CPU write wins; ST still sets.
  - CPU write clearing ST vs overflow: overflow wins, ST stays 1, OVR sets.
  - Write of TCON bit2=1 or bit3=1 does not set them (software can only clear).
- `MemRd` and `MemWr` both high: write performed, rdata still driven.

## Timing
- Reset values: TH=0, TL=0, TCON=0, PRESC=0, prescale counter=0, `rdata`=0, `Interrupt`=0.
- Reads: combinational, zero latency; `rdata` = selected register when `MemRd` & select, else 32'h0.
- Writes: visible in register from the next rising edge.
- Overflow to `Interrupt`: ST registers on the overflow edge; `Interrupt` rises in the same cycle after that edge (1-cycle latency from the TL==FFFF_FFFF tick).
- Clearing EN freezes TL and prescale counter; ST is retained.
- `reset` mid-count: everything returns to reset values immediately; `Interrupt` drops asynchronously.

## Configuration
- `TIMER_PRESCALE_EN` defined: 16-bit PRESC register at offset 0xC (bits 31:16 read 0); a prescale counter runs while EN=1. Tick fires when counter==PRESC; counter then returns to 0. Period in cycles = (PRESC+1)·(2^32−TH). Writing PRESC clears the prescale counter.
- Not defined: no PRESC storage; offset 0xC reads 0, writes ignored; tick every cycle.

## Test plan
- Reset, read all four offsets -> all return 32'h0, `Interrupt`=0.
- TH=FFFF_FFFC, TL=FFFF_FFFC, TCON=3, kernel=0 -> `Interrupt` rises after 4th counting edge; TL reloads to FFFF_FFFC; period 4 cycles.
- Let ST set, hold 4 more ticks without clearing -> OVR=1. Write TCON=3 -> ST=0, OVR=0, `Interrupt` low next cycle.
- ST=1, IE=1, toggle kernel 0->1->0 -> `Interrupt` follows ~kernel combinationally, ST unchanged.
- Write TCON=3 (clearing ST) on exact overflow edge -> ST remains 1, OVR=1, `Interrupt` stays high.
- With `TIMER_PRESCALE_EN`: PRESC=2, TH=TL=FFFF_FFFE, TCON=3 -> first `Interrupt` after 6 cycles. Without the macro: write 5 to 0xC, read back 0.

Source files
------------

// File: rtl/timer_irq_gen.sv
// Memory-mapped interval timer sourcing the level Interrupt request; masked while the CPU runs in kernel mode.
// Define TIMER_PRESCALE_EN to add the 16-bit prescaler register at offset 0xC.
module timer_irq_gen #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        MemRd,
    input  logic        MemWr,
    input  logic        kernel,
    output logic [31:0] rdata,
    output logic        Interrupt
);
    localparam logic [1:0] OFF_TH    = 2'd0;
    localparam logic [1:0] OFF_TL    = 2'd1;
    localparam logic [1:0] OFF_TCON  = 2'd2;
    localparam logic [1:0] OFF_PRESC = 2'd3;

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        en_q, en_d;
    logic        ie_q, ie_d;
    logic        st_q, st_d;
    logic        ovr_q, ovr_d;

    logic        sel;
    logic [1:0]  off;
    logic        wr_th, wr_tl, wr_tcon;
    logic        tick;
    logic        ovf;
    logic [31:0] presc_rd;
    logic        addr_lsb_unused;

    assign sel             = (addr[31:4] == BASE_ADDR[31:4]);
    assign off             = addr[3:2];
    assign addr_lsb_unused = ^addr[1:0];
    assign wr_th           = MemWr & sel & (off == OFF_TH);
    assign wr_tl           = MemWr & sel & (off == OFF_TL);
    assign wr_tcon         = MemWr & sel & (off == OFF_TCON);

`ifdef TIMER_PRESCALE_EN
    logic [15:0] presc_q, presc_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        wr_presc;

    assign wr_presc = MemWr & sel & (off == OFF_PRESC);
    assign tick     = (pcnt_q == presc_q);
    assign presc_rd = {16'h0, presc_q};

    // The prescale counter only advances while counting is enabled.
    always_comb begin
        presc_d = presc_q;
        pcnt_d  = pcnt_q;
        if (wr_presc) begin
            presc_d = wdata[15:0];
            pcnt_d  = 16'h0;
        end else if (en_q) begin
            pcnt_d = tick ? 16'h0 : pcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= 16'h0;
            pcnt_q  <= 16'h0;
        end else begin
            presc_q <= presc_d;
            pcnt_q  <= pcnt_d;
        end
    end
`else
    assign tick     = 1'b1;
    assign presc_rd = 32'h0;
`endif

    assign ovf = en_q & tick & (tl_q == 32'hFFFF_FFFF);

    // Later assignments take priority: CPU writes beat the reload, overflow beats a status clear.
    always_comb begin
        th_d  = th_q;
        tl_d  = tl_q;
        en_d  = en_q;
        ie_d  = ie_q;
        st_d  = st_q;
        ovr_d = ovr_q;
        if (en_q && tick)
            tl_d = ovf ? th_q : tl_q + 32'd1;
        if (wr_th)
            th_d = wdata;
        if (wr_tl)
            tl_d = wdata;
        if (wr_tcon) begin
            en_d  = wdata[0];
            ie_d  = wdata[1];
            st_d  = st_q & wdata[2];
            ovr_d = ovr_q & wdata[3];
        end
        if (ovf) begin
            st_d = 1'b1;
            if (st_q)
                ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q  <= 32'h0;
            tl_q  <= 32'h0;
            en_q  <= 1'b0;
            ie_q  <= 1'b0;
            st_q  <= 1'b0;
            ovr_q <= 1'b0;
        end else begin
            th_q  <= th_d;
            tl_q  <= tl_d;
            en_q  <= en_d;
            ie_q  <= ie_d;
            st_q  <= st_d;
            ovr_q <= ovr_d;
        end
    end

    always_comb begin
        rdata = 32'h0;
        if (MemRd && sel) begin
            case (off)
                OFF_TH:   rdata = th_q;
                OFF_TL:   rdata = tl_q;
                OFF_TCON: rdata = {28'h0, ovr_q, st_q, ie_q, en_q};
                default:  rdata = presc_rd;
            endcase
        end
    end

    assign Interrupt = st_q & ie_q & ~kernel;

endmodule

// File: tb/tb_timer_irq_gen.sv
// Scoreboard bench for timer_irq_gen: expectations are queued with each stimulus and popped when the DUT output is sampled.
`timescale 1ns/1ps
module tb_timer_irq_gen;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        MemRd = 1'b0;
    logic        MemWr = 1'b0;
    logic        kernel = 1'b0;
    logic [31:0] rdata;
    logic        Interrupt;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got, e;
    int          cyc;

    timer_irq_gen #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
        .MemRd(MemRd), .MemWr(MemWr), .kernel(kernel),
        .rdata(rdata), .Interrupt(Interrupt)
    );

    always #50 clk = ~clk;

    // Write lands on the next rising edge; returns 1ns after that edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; MemWr = 1'b1;
        @(posedge clk); #1;
        MemWr = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; MemRd = 1'b1;
        #1 d = rdata;
        MemRd = 1'b0; addr = 32'h0;
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset;
        tick_n(2);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            bus_read(BASE + 32'(i * 4), got);
            n_chk++; e = exp_q.pop_front();
            if (got !== e) begin n_err++; $display("FAIL reset_reg%0d got=%h exp=%h", i, got, e); end
        end
        exp_q.push_back(32'h0); got = {31'h0, Interrupt};
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL reset_irq got=%h exp=%h", got, e); end
        reset = 1'b0;
        tick_n(1);
    endtask

    task automatic test_overflow;
        bus_write(BASE + 32'h0, 32'hFFFF_FFFC);
        bus_write(BASE + 32'h4, 32'hFFFF_FFFC);
        bus_write(BASE + 32'h8, 32'h3);
        for (int i = 1; i <= 4; i++) begin
            tick_n(1);
            exp_q.push_back((i == 4) ? 32'hFFFF_FFFC : 32'hFFFF_FFFC + 32'(i));
            exp_q.push_back((i == 4) ? 32'h1 : 32'h0);
            bus_read(BASE + 32'h4, got);
            n_chk++; e = exp_q.pop_front();
            if (got !== e) begin n_err++; $display("FAIL ovf_tl_%0d got=%h exp=%h", i, got, e); end
            got = {31'h0, Interrupt};
            n_chk++; e = exp_q.pop_front();
            if (got !== e) begin n_err++; $display("FAIL ovf_irq_%0d got=%h exp=%h", i, got, e); end
        end
        exp_q.push_back(32'h7); bus_read(BASE + 32'h8, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL ovf_tcon got=%h exp=%h", got, e); end
        tick_n(4);
        exp_q.push_back(32'hF); bus_read(BASE + 32'h8, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL overrun_tcon got=%h exp=%h", got, e); end
        exp_q.push_back(32'hFFFF_FFFC); bus_read(BASE + 32'h4, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL reload_tl got=%h exp=%h", got, e); end
        bus_write(BASE + 32'h8, 32'h3);
        exp_q.push_back(32'h3); bus_read(BASE + 32'h8, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL clear_tcon got=%h exp=%h", got, e); end
        exp_q.push_back(32'h0); got = {31'h0, Interrupt};
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL clear_irq got=%h exp=%h", got, e); end
    endtask

    task automatic test_kernel_mask;
        exp_q.push_back(32'd3);
        cyc = 0;
        while (Interrupt !== 1'b1 && cyc < 20) begin tick_n(1); cyc++; end
        got = 32'(cyc);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL period_cycles got=%0d exp=%0d", got, e); end
        bus_write(BASE + 32'h8, 32'h6);
        tick_n(2);
        exp_q.push_back(32'h6); bus_read(BASE + 32'h8, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL frozen_tcon got=%h exp=%h", got, e); end
        exp_q.push_back(32'hFFFF_FFFD); bus_read(BASE + 32'h4, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL frozen_tl got=%h exp=%h", got, e); end
        for (int k = 0; k < 3; k++) begin
            kernel = (k == 1);
            exp_q.push_back((k == 1) ? 32'h0 : 32'h1);
            #1 got = {31'h0, Interrupt};
            n_chk++; e = exp_q.pop_front();
            if (got !== e) begin n_err++; $display("FAIL kernel_mask_%0d got=%h exp=%h", k, got, e); end
        end
        exp_q.push_back(32'h6); bus_read(BASE + 32'h8, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL kernel_st got=%h exp=%h", got, e); end
    endtask

    task automatic test_collision;
        bus_write(BASE + 32'h4, 32'hFFFF_FFFE);
        bus_write(BASE + 32'h8, 32'h7);
        tick_n(1);
        exp_q.push_back(32'hFFFF_FFFF); bus_read(BASE + 32'h4, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL coll_pre_tl got=%h exp=%h", got, e); end
        bus_write(BASE + 32'h8, 32'h3);
        exp_q.push_back(32'hF); bus_read(BASE + 32'h8, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL coll_clear_tcon got=%h exp=%h", got, e); end
        exp_q.push_back(32'h1); got = {31'h0, Interrupt};
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL coll_clear_irq got=%h exp=%h", got, e); end
        bus_write(BASE + 32'h8, 32'h3);
        tick_n(2);
        exp_q.push_back(32'hFFFF_FFFF); bus_read(BASE + 32'h4, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL coll_pre2_tl got=%h exp=%h", got, e); end
        bus_write(BASE + 32'h4, 32'h0000_1234);
        exp_q.push_back(32'h0000_1234); bus_read(BASE + 32'h4, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL coll_wr_tl got=%h exp=%h", got, e); end
        exp_q.push_back(32'h7); bus_read(BASE + 32'h8, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL coll_wr_tcon got=%h exp=%h", got, e); end
    endtask

    task automatic test_sw_cannot_set;
        bus_write(BASE + 32'h8, 32'h0);
        bus_write(BASE + 32'h8, 32'hFFFF_FFFE);
        exp_q.push_back(32'h2); bus_read(BASE + 32'h8, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL sw_set_tcon got=%h exp=%h", got, e); end
        exp_q.push_back(32'h0); got = {31'h0, Interrupt};
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL sw_set_irq got=%h exp=%h", got, e); end
    endtask

    task automatic test_decode;
        bus_write(BASE + 32'h0, 32'h0000_00AA);
        bus_write(BASE + 32'h10, 32'h0000_0055);
        exp_q.push_back(32'h0000_00AA); bus_read(BASE + 32'h0, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL dec_th got=%h exp=%h", got, e); end
        exp_q.push_back(32'h0000_00AA); bus_read(BASE + 32'h1, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL dec_lsb got=%h exp=%h", got, e); end
        exp_q.push_back(32'h0); bus_read(BASE + 32'h10, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL dec_unsel got=%h exp=%h", got, e); end
        addr = BASE; MemRd = 1'b0;
        exp_q.push_back(32'h0);
        #1 got = rdata;
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL dec_no_rd got=%h exp=%h", got, e); end
        wdata = 32'h0000_00BB; MemWr = 1'b1; MemRd = 1'b1;
        exp_q.push_back(32'h0000_00AA); exp_q.push_back(32'h0000_00BB);
        #1 got = rdata;
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL rdwr_before got=%h exp=%h", got, e); end
        @(posedge clk); #1 got = rdata;
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL rdwr_after got=%h exp=%h", got, e); end
        MemWr = 1'b0; MemRd = 1'b0; addr = 32'h0; wdata = 32'h0;
    endtask

    task automatic test_prescale;
`ifdef TIMER_PRESCALE_EN
        bus_write(BASE + 32'h8, 32'h0);
        bus_write(BASE + 32'hC, 32'hFFFF_0002);
        bus_write(BASE + 32'h0, 32'hFFFF_FFFE);
        bus_write(BASE + 32'h4, 32'hFFFF_FFFE);
        exp_q.push_back(32'h2); bus_read(BASE + 32'hC, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL presc_rd got=%h exp=%h", got, e); end
        bus_write(BASE + 32'h8, 32'h3);
        exp_q.push_back(32'd6);
        cyc = 0;
        while (Interrupt !== 1'b1 && cyc < 40) begin tick_n(1); cyc++; end
        got = 32'(cyc);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL presc_cycles got=%0d exp=%0d", got, e); end
        exp_q.push_back(32'hFFFF_FFFE); bus_read(BASE + 32'h4, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL presc_reload got=%h exp=%h", got, e); end
`else
        bus_write(BASE + 32'hC, 32'h5);
        exp_q.push_back(32'h0); bus_read(BASE + 32'hC, got);
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL presc_absent got=%h exp=%h", got, e); end
`endif
    endtask

    task automatic test_reset_mid;
        bus_write(BASE + 32'h8, 32'h0);
        bus_write(BASE + 32'hC, 32'h0);
        bus_write(BASE + 32'h0, 32'hFFFF_FFFC);
        bus_write(BASE + 32'h4, 32'hFFFF_FFFF);
        bus_write(BASE + 32'h8, 32'h3);
        tick_n(1);
        exp_q.push_back(32'h1); got = {31'h0, Interrupt};
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL mid_irq_pre got=%h exp=%h", got, e); end
        #10 reset = 1'b1;
        exp_q.push_back(32'h0);
        #1 got = {31'h0, Interrupt};
        n_chk++; e = exp_q.pop_front();
        if (got !== e) begin n_err++; $display("FAIL mid_irq_async got=%h exp=%h", got, e); end
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'h0);
            bus_read(BASE + 32'(i * 4), got);
            n_chk++; e = exp_q.pop_front();
            if (got !== e) begin n_err++; $display("FAIL mid_reg%0d got=%h exp=%h", i, got, e); end
        end
        @(posedge clk); #1 reset = 1'b0;
    endtask

    initial begin
        test_reset;
        test_overflow;
        test_kernel_mask;
        test_collision;
        test_sw_cannot_set;
        test_decode;
        test_prescale;
        test_reset_mid;
        if (exp_q.size() != 0) begin
            n_chk++; n_err++;
            $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
